rv32_muldiv_iter: RTL

Parametrised iterative RV32M multiply/divide unit with a start/done handshake, kill, and busy signalling. It is the stall-aware successor to the single-shot `rv32_mul_div` block. The core launches an M-extension operation from Execute and holds the pipeline on `busy_o`. The result is returned tagged with its destination register for writeback. Operand width and multiplier throughput are configurable, and division can be compiled out.

---
 rtl/rv32_muldiv_iter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_muldiv_iter.sv
// rv32_muldiv_iter: iterative RV32M multiply/divide with start/done handshake, kill and busy.
// The restoring divider is built only when RV32_MULDIV_DIV_EN is defined; otherwise ops 4-7 report err_o.
module rv32_muldiv_iter #(
   parameter int XLEN               = 32,
   parameter int MUL_BITS_PER_CYCLE = 2
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [2:0]      op_i,
   input  logic [4:0]      rd_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   output logic            ready_o,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);
   localparam int K         = MUL_BITS_PER_CYCLE;
   localparam int MUL_ITERS = XLEN / K;
   localparam int CW        = $clog2(XLEN) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
`ifdef RV32_MULDIV_DIV_EN
      S_DIV,
`endif
      S_FIXUP,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_ready;
   logic              w_busy;
   logic              w_done;
   logic              w_accept;

   logic [2:0]        r_op;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_a;
   logic [2*XLEN-1:0] r_prod;
   logic              r_neg;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_result;
   logic              r_err;
   logic [4:0]        r_rd_out;

   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_abs;
   logic [XLEN-1:0]   w_b_abs;

   logic [XLEN-1:0]   w_fix_result;
   logic              w_fix_err;
   logic [2*XLEN-1:0] w_prod_fix;

   always_comb begin
      w_a_signed = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd2) ||
                   (op_i == 3'd4) || (op_i == 3'd6);
      w_b_signed = (op_i == 3'd0) || (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
      w_a_neg    = w_a_signed && operand_a_i[XLEN-1];
      w_b_neg    = w_b_signed && operand_b_i[XLEN-1];
      w_a_abs    = w_a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
      w_b_abs    = w_b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
   end

   // Shift-add step: high half accumulates r_a times the low K multiplier bits, then shifts right by K.
   logic [XLEN+K-1:0] w_pp [0:K];
   logic [XLEN+K-1:0] w_mul_upper;
   logic [2*XLEN-1:0] w_mul_next;

   assign w_pp[0] = '0;
   for (genvar gi = 0; gi < K; gi++) begin : g_pp
      assign w_pp[gi+1] = w_pp[gi] + (r_prod[gi] ? ({{K{1'b0}}, r_a} << gi) : '0);
   end
   assign w_mul_upper = {{K{1'b0}}, r_prod[2*XLEN-1:XLEN]} + w_pp[K];
   assign w_mul_next  = {w_mul_upper, r_prod[XLEN-1:K]};

`ifdef RV32_MULDIV_DIV_EN
   // r_prod holds {remainder, quotient/dividend}; r_a holds |divisor|.
   logic              r_neg_rem;
   logic [XLEN:0]     w_div_shift;
   logic [XLEN:0]     w_div_diff;
   logic              w_div_ge;
   logic [2*XLEN-1:0] w_div_next;
   logic              w_div_zero;
   logic              w_ovf;
   logic              w_fast;

   assign w_div_shift = r_prod[2*XLEN-1:XLEN-1];
   assign w_div_diff  = w_div_shift - {1'b0, r_a};
   assign w_div_ge    = !w_div_diff[XLEN];
   assign w_div_next  = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                         r_prod[XLEN-2:0], w_div_ge};
   assign w_div_zero  = (operand_b_i == '0);
   assign w_ovf       = ((op_i == 3'd4) || (op_i == 3'd6)) &&
                        (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b_i);
   assign w_fast      = w_div_zero || w_ovf;
`endif

   assign w_accept = start_i && w_ready && !kill_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (!w_accept)      w_state_next = S_IDLE;
            else if (!op_i[2])  w_state_next = S_MUL;
`ifdef RV32_MULDIV_DIV_EN
            else if (!w_fast)   w_state_next = S_DIV;
`endif
            else                w_state_next = S_FIXUP;
         end
         S_MUL: begin
            if (kill_i)              w_state_next = S_IDLE;
            else if (r_cnt == '0)    w_state_next = S_FIXUP;
         end
`ifdef RV32_MULDIV_DIV_EN
         S_DIV: begin
            if (kill_i)              w_state_next = S_IDLE;
            else if (r_cnt == '0)    w_state_next = S_FIXUP;
         end
`endif
         S_FIXUP: w_state_next = kill_i ? S_IDLE : S_DONE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ready = (r_state == S_IDLE) || (r_state == S_DONE);
      w_busy  = (r_state == S_MUL) || (r_state == S_FIXUP)
`ifdef RV32_MULDIV_DIV_EN
                || (r_state == S_DIV)
`endif
                ;
      w_done  = (r_state == S_DONE);
   end

   // Sign is applied to the full-width product so MULH* see the correct high half.
   always_comb begin
      w_prod_fix   = r_neg ? (~r_prod + 1'b1) : r_prod;
      w_fix_result = '0;
      w_fix_err    = 1'b0;
      case (r_op)
         3'd0:                w_fix_result = w_prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
`ifdef RV32_MULDIV_DIV_EN
         3'd4, 3'd5:          w_fix_result = w_prod_fix[XLEN-1:0];
         default:             w_fix_result = r_neg_rem ? (~r_prod[2*XLEN-1:XLEN] + 1'b1)
                                                       : r_prod[2*XLEN-1:XLEN];
`else
         default:             w_fix_err    = 1'b1;
`endif
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_op      <= '0;
         r_rd      <= '0;
         r_a       <= '0;
         r_prod    <= '0;
         r_neg     <= 1'b0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_err     <= 1'b0;
         r_rd_out  <= '0;
`ifdef RV32_MULDIV_DIV_EN
         r_neg_rem <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_op <= op_i;
            r_rd <= rd_i;
            if (!op_i[2]) begin
               r_a    <= w_a_abs;
               r_prod <= {{XLEN{1'b0}}, w_b_abs};
               r_neg  <= w_a_neg ^ w_b_neg;
               r_cnt  <= CW'(MUL_ITERS - 1);
            end else begin
`ifdef RV32_MULDIV_DIV_EN
               r_a   <= w_b_abs;
               r_cnt <= CW'(XLEN - 1);
               if (w_div_zero) begin
                  r_prod    <= {operand_a_i, {XLEN{1'b1}}};
                  r_neg     <= 1'b0;
                  r_neg_rem <= 1'b0;
               end else if (w_ovf) begin
                  r_prod    <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                  r_neg     <= 1'b0;
                  r_neg_rem <= 1'b0;
               end else begin
                  r_prod    <= {{XLEN{1'b0}}, w_a_abs};
                  r_neg     <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= w_a_neg;
               end
`else
               r_neg <= 1'b0;
`endif
            end
         end else if (r_state == S_MUL) begin
            r_prod <= w_mul_next;
            r_cnt  <= r_cnt - 1'b1;
`ifdef RV32_MULDIV_DIV_EN
         end else if (r_state == S_DIV) begin
            r_prod <= w_div_next;
            r_cnt  <= r_cnt - 1'b1;
`endif
         end else if ((r_state == S_FIXUP) && !kill_i) begin
            r_result <= w_fix_result;
            r_err    <= w_fix_err;
            r_rd_out <= r_rd;
         end
      end
   end

   assign ready_o  = w_ready;
   assign busy_o   = w_busy;
   assign done_o   = w_done;
   assign err_o    = r_err;
   assign result_o = r_result;
   assign rd_o     = r_rd_out;
endmodule
